// File: rtl/difftest_debug_mode_tracker.sv
// Detects any change in the core's debug-mode CSR snapshot, queues changed snapshots and
// replays one per drained cycle (enable one cycle after push when empty; full+no-drain drops intermediates, keeps newest).
module difftest_debug_mode_tracker #(
  parameter int DEPTH    = 4,
  parameter int XLEN     = 64,
  parameter int COREID_W = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     io_debugMode,
  input  logic [XLEN-1:0]          io_dcsr,
  input  logic [XLEN-1:0]          io_dpc,
  input  logic [XLEN-1:0]          io_dscratch0,
  input  logic [XLEN-1:0]          io_dscratch1,
  input  logic [COREID_W-1:0]      io_coreid,
  input  logic                     io_drain_en,
  output logic                     enable,
  output logic                     out_debugMode,
  output logic [XLEN-1:0]          out_dcsr,
  output logic [XLEN-1:0]          out_dpc,
  output logic [XLEN-1:0]          out_dscratch0,
  output logic [XLEN-1:0]          out_dscratch1,
  output logic [COREID_W-1:0]      out_coreid,
  output logic [$clog2(DEPTH):0]   io_count,
  output logic                     io_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic            debug_mode;
    logic [XLEN-1:0] dcsr;
    logic [XLEN-1:0] dpc;
    logic [XLEN-1:0] dscratch0;
    logic [XLEN-1:0] dscratch1;
  } snap_t;

  snap_t          live;
  snap_t          head;
  snap_t          last_q;
  snap_t          mem_q [DEPTH];
  logic           first_q;
  logic           overflow_q;
  logic [AW-1:0]  wr_ptr_q;
  logic [AW-1:0]  rd_ptr_q;
  logic [CW-1:0]  count_q;

  logic empty;
  logic full;
  logic change;
  logic push;
  logic pop;

  always_comb begin
    live            = '0;
    live.debug_mode = io_debugMode;
    live.dcsr       = io_dcsr;
    live.dpc        = io_dpc;
    live.dscratch0  = io_dscratch0;
    live.dscratch1  = io_dscratch1;
  end

  assign empty  = (count_q == '0);
  assign full   = (count_q == CW'(DEPTH));
  // first_q forces the initial snapshot out even if it matches the all-zero reset value of last_q
  assign change = first_q | (live != last_q);
  assign pop    = ~empty & io_drain_en;
  assign push   = change & (~full | pop);

  assign head          = mem_q[rd_ptr_q];
  assign enable        = pop;
  assign out_debugMode = head.debug_mode;
  assign out_dcsr      = head.dcsr;
  assign out_dpc       = head.dpc;
  assign out_dscratch0 = head.dscratch0;
  assign out_dscratch1 = head.dscratch1;
  assign out_coreid    = io_coreid;
  assign io_count      = count_q;
  assign io_overflow   = overflow_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      last_q     <= '0;
      first_q    <= 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= live;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
        last_q          <= live;
        first_q         <= 1'b0;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CW'(1);
      end
      // A held-back change stays pending against last_q and goes in once a slot frees
      if (change && !push) begin
        overflow_q <= 1'b1;
      end
    end
  end

endmodule
